// File: rtl/wl_afifo_pkg.sv
// Shared helpers for the wl async FIFO pointer stages: default address width and
// Gray/binary conversions usable at any pointer width up to WL_FN_W bits.
package wl_afifo_pkg;

    localparam int WL_DEFAULT_L = 3;
    localparam int WL_FN_W      = 32;

    function automatic logic [WL_FN_W-1:0] bin2gray(input logic [WL_FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended inputs leave the low bits unaffected.
    function automatic logic [WL_FN_W-1:0] gray2bin(input logic [WL_FN_W-1:0] g);
        logic [WL_FN_W-1:0] b;
        b = g;
        for (int s = 1; s < WL_FN_W; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/wl_sync2.sv
// Two-flop synchroniser for a multi-bit Gray-coded bus crossing into i_clk's domain.
module wl_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/wl_afifo_wptr_full.sv
// Write-domain pointer/flag stage of the wl async FIFO: qualifies writes, owns the
// binary and Gray write pointers and derives full/almost-full/occupancy from the synced read pointer.
module wl_afifo_wptr_full
    import wl_afifo_pkg::*;
#(
    parameter int L        = WL_DEFAULT_L,
    parameter int AF_LEVEL = 2**L - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_req,
    input  logic [L:0]   gray_rptr,
    output logic         we,
    output logic [L:0]   bin_wptr,
    output logic [L:0]   gray_wptr,
    output logic         full,
    output logic         afull,
    output logic [L:0]   wcount
);

    localparam int PW = L + 1;

    logic [L:0] w_rq2;
    logic [L:0] w_rbin;
    logic [L:0] w_bin_next;
    logic [L:0] w_gray_next;
    logic [L:0] w_full_tgt;
    logic [L:0] w_diff;
    logic       w_we;

    logic [L:0] r_bin;
    logic [L:0] r_gray;
    logic [L:0] r_wcount;
    logic       r_full;
    logic       r_afull;

    wl_sync2 #(.WIDTH(PW)) u_rptr_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (gray_rptr),
        .o_q   (w_rq2)
    );

    assign w_we        = wr_req & ~r_full;
    assign w_bin_next  = r_bin + {{L{1'b0}}, w_we};
    assign w_gray_next = PW'(bin2gray(WL_FN_W'(w_bin_next)));
    assign w_rbin      = PW'(gray2bin(WL_FN_W'(w_rq2)));
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign w_full_tgt  = {~w_rq2[L:L-1], w_rq2[L-2:0]};
    assign w_diff      = w_bin_next - w_rbin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin    <= '0;
            r_gray   <= '0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_wcount <= '0;
        end else begin
            r_bin    <= w_bin_next;
            r_gray   <= w_gray_next;
            r_full   <= (w_gray_next == w_full_tgt);
            r_afull  <= (w_diff >= PW'(AF_LEVEL));
            r_wcount <= w_diff;
        end
    end

    assign we        = w_we;
    assign bin_wptr  = r_bin;
    assign gray_wptr = r_gray;
    assign full      = r_full;
    assign afull     = r_afull;
    assign wcount    = r_wcount;

endmodule
